pc_sequencer: RTL and testbench

Multicycle next-PC sequencer for the datapath fetch path. It accepts one PC-update request per instruction from the main control FSM. It drives the 3-bit select of the PC-source mux, plus the PC and EPC write enables. For exceptions it runs a multi-cycle vector fetch, reading the handler address from memory before loading PC.

---
 rtl/pc_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle next-PC sequencer for the fetch datapath.
// Accepts one PC-update request per instruction from the main control FSM
// and drives the PC-source mux select plus the PC/EPC write enables.
// Exceptions run a vector fetch: EPC is written, the handler address is read
// from memory at VEC_BASE+code, and after MEM_LAT cycles PC is loaded from it.
//
// Parameters:
//   MEM_LAT   cycles from vec_rd to vector data valid at mux input 4 (1..7)
//   VEC_BASE  byte address of the vector for exception code 0
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   req_valid    in   request present
//   req_ready    out  request can be accepted (IDLE only)
//   req_kind     in   0 NEXT, 1 BRANCH, 2 JUMP, 3 JR, 4 EXC, 5 ERET, 6/7 illegal
//   branch_cond  in   branch outcome, sampled at accept
//   exc_code     in   exception cause, sampled at accept (3 maps to 0)
//   pc_source    out  mux select: 001 PC+4, 000 branch, 010 jump,
//                     100 memory vector, 101 EPC/register
//   pc_write     out  one-cycle PC load strobe
//   epc_write    out  one-cycle EPC load strobe
//   vec_rd       out  one-cycle vector read strobe
//   vec_addr     out  vector byte address, held after the read
//   done         out  one-cycle completion pulse
//   busy         out  high in every state except IDLE
//
// Configuration macro:
//   PCSEQ_ERET_EN  defined: ERET selects 101 and writes PC like JR.
//                  undefined: ERET is illegal and takes the EXC path, code 0.
module pc_sequencer #(
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic        branch_cond,
  input  logic [1:0]  exc_code,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic        vec_rd,
  output logic [31:0] vec_addr,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_VEC_WAIT = 2'd2,
    S_VEC_LOAD = 2'd3
  } state_t;

  localparam logic [2:0] PCS_PC4 = 3'b001;
  localparam logic [2:0] PCS_BR  = 3'b000;
  localparam logic [2:0] PCS_JMP = 3'b010;
  localparam logic [2:0] PCS_VEC = 3'b100;
  localparam logic [2:0] PCS_EPC = 3'b101;

  localparam logic [2:0] K_NEXT   = 3'd0;
  localparam logic [2:0] K_BRANCH = 3'd1;
  localparam logic [2:0] K_JUMP   = 3'd2;
  localparam logic [2:0] K_JR     = 3'd3;
  localparam logic [2:0] K_EXC    = 3'd4;
  localparam logic [2:0] K_ERET   = 3'd5;

  localparam logic [2:0]  LAT_M1  = 3'(MEM_LAT - 1);
  localparam logic [32:0] VEC_TOP = {1'b0, VEC_BASE} + 33'd3;

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_chk
    $error("pc_sequencer: MEM_LAT must be in 1..7");
  end
  if (VEC_TOP[32]) begin : g_base_chk
    $error("pc_sequencer: VEC_BASE+3 wraps 32 bits");
  end

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_pc_source, w_pc_source_nxt;
  logic        r_pc_write, w_pc_write_nxt;
  logic        r_epc_write, w_epc_write_nxt;
  logic        r_vec_rd, w_vec_rd_nxt;
  logic [31:0] r_vec_addr, w_vec_addr_nxt;
  logic        r_done, w_done_nxt;
  logic        r_busy;
  logic        r_req_ready;
  logic        w_accept;
  logic        w_is_exc;
  logic [1:0]  w_code;

  assign w_accept = req_valid && r_req_ready && (r_state == S_IDLE);

  // Outputs are computed for the state being entered, so each registered
  // strobe lines up with the cycle spent in that state.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_source_nxt = r_pc_source;
    w_pc_write_nxt  = 1'b0;
    w_epc_write_nxt = 1'b0;
    w_vec_rd_nxt    = 1'b0;
    w_vec_addr_nxt  = r_vec_addr;
    w_done_nxt      = 1'b0;
    w_is_exc        = 1'b0;
    w_code          = 2'd0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Anything not decoded as a simple kind falls through to EXC.
          w_is_exc = 1'b1;
          case (req_kind)
            K_NEXT: begin
              w_is_exc        = 1'b0;
              w_pc_source_nxt = PCS_PC4;
              w_pc_write_nxt  = 1'b1;
            end
            K_BRANCH: begin
              w_is_exc        = 1'b0;
              w_pc_source_nxt = branch_cond ? PCS_BR : PCS_PC4;
              w_pc_write_nxt  = branch_cond;
            end
            K_JUMP: begin
              w_is_exc        = 1'b0;
              w_pc_source_nxt = PCS_JMP;
              w_pc_write_nxt  = 1'b1;
            end
            K_JR: begin
              w_is_exc        = 1'b0;
              w_pc_source_nxt = PCS_EPC;
              w_pc_write_nxt  = 1'b1;
            end
`ifdef PCSEQ_ERET_EN
            K_ERET: begin
              w_is_exc        = 1'b0;
              w_pc_source_nxt = PCS_EPC;
              w_pc_write_nxt  = 1'b1;
            end
`endif
            default: ;
          endcase

          if (w_is_exc) begin
            // Only a genuine EXC carries a cause; reserved code 3 and all
            // illegal kinds use vector 0.
            if (req_kind == K_EXC && exc_code != 2'd3) w_code = exc_code;
            w_state_nxt     = S_ISSUE;
            w_epc_write_nxt = 1'b1;
            w_vec_rd_nxt    = 1'b1;
            w_vec_addr_nxt  = VEC_BASE + {30'd0, w_code};
            w_cnt_nxt       = LAT_M1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = (LAT_M1 == 3'd0) ? S_VEC_LOAD : S_VEC_WAIT;
      end
      S_VEC_WAIT: begin
        // Counter value 1 here means it reaches 0 on this edge.
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_state_nxt = S_VEC_LOAD;
      end
      S_VEC_LOAD: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (r_state != S_VEC_LOAD && w_state_nxt == S_VEC_LOAD) begin
      w_pc_source_nxt = PCS_VEC;
      w_pc_write_nxt  = 1'b1;
      w_done_nxt      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_pc_source <= PCS_PC4;
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_vec_rd    <= 1'b0;
      r_vec_addr  <= 32'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pc_source <= w_pc_source_nxt;
      r_pc_write  <= w_pc_write_nxt;
      r_epc_write <= w_epc_write_nxt;
      r_vec_rd    <= w_vec_rd_nxt;
      r_vec_addr  <= w_vec_addr_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_req_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign pc_source = r_pc_source;
  assign pc_write  = r_pc_write;
  assign epc_write = r_epc_write;
  assign vec_rd    = r_vec_rd;
  assign vec_addr  = r_vec_addr;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (MEM_LAT=2,
// VEC_BASE=253). Expected values are hand-computed constants.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic        branch_cond;
  logic [1:0]  exc_code;
  logic [2:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic        vec_rd;
  logic [31:0] vec_addr;
  logic        done;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .branch_cond (branch_cond),
    .exc_code    (exc_code),
    .pc_source   (pc_source),
    .pc_write    (pc_write),
    .epc_write   (epc_write),
    .vec_rd      (vec_rd),
    .vec_addr    (vec_addr),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compact check of the full output set.
  task automatic chk_all(input string tag, input logic [2:0] e_pcs, input logic e_pw,
                         input logic e_epc, input logic e_vrd, input logic e_done,
                         input logic e_busy, input logic e_rdy);
    chk({tag, ".pc_source"}, {29'd0, pc_source}, {29'd0, e_pcs});
    chk({tag, ".pc_write"},  {31'd0, pc_write},  {31'd0, e_pw});
    chk({tag, ".epc_write"}, {31'd0, epc_write}, {31'd0, e_epc});
    chk({tag, ".vec_rd"},    {31'd0, vec_rd},    {31'd0, e_vrd});
    chk({tag, ".done"},      {31'd0, done},      {31'd0, e_done});
    chk({tag, ".busy"},      {31'd0, busy},      {31'd0, e_busy});
    chk({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, e_rdy});
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_kind    = 3'd0;
    branch_cond = 1'b0;
    exc_code    = 2'd0;
    #1;

    // Reset held 3 cycles, then released
    step(); step(); step();
    chk_all("rst_held", 3'b001, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    step();
    chk_all("rst_rel", 3'b001, 0, 0, 0, 0, 0, 1);
    chk("rst_rel.vec_addr", vec_addr, 32'd0);

    // NEXT, JUMP, JR back to back
    req_valid = 1'b1; req_kind = 3'd0;
    step();
    chk_all("next", 3'b001, 1, 0, 0, 1, 0, 1);
    req_kind = 3'd2;
    step();
    chk_all("jump", 3'b010, 1, 0, 0, 1, 0, 1);
    req_kind = 3'd3;
    step();
    chk_all("jr", 3'b101, 1, 0, 0, 1, 0, 1);
    req_valid = 1'b0;
    step();
    chk_all("jr_after", 3'b101, 0, 0, 0, 0, 0, 1);

    // BRANCH not taken, then taken
    req_valid = 1'b1; req_kind = 3'd1; branch_cond = 1'b0;
    step();
    chk_all("br_nt", 3'b001, 0, 0, 0, 1, 0, 1);
    branch_cond = 1'b1;
    step();
    chk_all("br_t", 3'b000, 1, 0, 0, 1, 0, 1);
    req_valid = 1'b0; branch_cond = 1'b0;
    step();
    chk_all("br_after", 3'b000, 0, 0, 0, 0, 0, 1);

    // EXC code 1 with a NEXT held while busy
    req_valid = 1'b1; req_kind = 3'd4; exc_code = 2'd1;
    step();
    chk_all("exc1_t1", 3'b000, 0, 1, 1, 0, 1, 0);
    chk("exc1_t1.vec_addr", vec_addr, 32'd254);
    req_kind = 3'd0; exc_code = 2'd0;
    step();
    chk_all("exc1_t2", 3'b000, 0, 0, 0, 0, 1, 0);
    chk("exc1_t2.vec_addr", vec_addr, 32'd254);
    step();
    chk_all("exc1_t3", 3'b100, 1, 0, 0, 1, 1, 0);
    step();
    chk_all("exc1_t4", 3'b100, 0, 0, 0, 0, 0, 1);
    step();
    chk_all("held_next", 3'b001, 1, 0, 0, 1, 0, 1);
    req_valid = 1'b0;
    step();
    chk_all("held_after", 3'b001, 0, 0, 0, 0, 0, 1);

    // EXC code 3 maps to vector 0
    req_valid = 1'b1; req_kind = 3'd4; exc_code = 2'd3;
    step();
    chk_all("exc3_t1", 3'b001, 0, 1, 1, 0, 1, 0);
    chk("exc3_t1.vec_addr", vec_addr, 32'd253);
    req_valid = 1'b0; exc_code = 2'd0;
    step(); step();
    chk_all("exc3_t3", 3'b100, 1, 0, 0, 1, 1, 0);
    step();
    chk_all("exc3_t4", 3'b100, 0, 0, 0, 0, 0, 1);

    // Kind 5: ERET when enabled, otherwise an EXC with code 0
    req_valid = 1'b1; req_kind = 3'd5; exc_code = 2'd2;
`ifdef PCSEQ_ERET_EN
    step();
    chk_all("eret", 3'b101, 1, 0, 0, 1, 0, 1);
    req_valid = 1'b0;
    step();
    chk_all("eret_after", 3'b101, 0, 0, 0, 0, 0, 1);
`else
    step();
    chk_all("k5_t1", 3'b100, 0, 1, 1, 0, 1, 0);
    chk("k5_t1.vec_addr", vec_addr, 32'd253);
    req_valid = 1'b0;
    step(); step();
    chk_all("k5_t3", 3'b100, 1, 0, 0, 1, 1, 0);
    step();
    chk_all("k5_t4", 3'b100, 0, 0, 0, 0, 0, 1);
`endif

    // Kind 6 is illegal: vector 0 regardless of exc_code
    req_valid = 1'b1; req_kind = 3'd6; exc_code = 2'd2;
    step();
    chk("k6_t1.vec_rd", {31'd0, vec_rd}, 32'd1);
    chk("k6_t1.vec_addr", vec_addr, 32'd253);
    req_valid = 1'b0;
    step(); step(); step();
    chk_all("k6_t4", 3'b100, 0, 0, 0, 0, 0, 1);

    // Reset mid-sequence aborts an EXC (code 2)
    req_valid = 1'b1; req_kind = 3'd4; exc_code = 2'd2;
    step();
    chk("abort_t1.vec_addr", vec_addr, 32'd255);
    chk("abort_t1.vec_rd", {31'd0, vec_rd}, 32'd1);
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_all("abort_t3", 3'b001, 0, 0, 0, 0, 0, 1);
    chk("abort_t3.vec_addr", vec_addr, 32'd0);
    reset = 1'b0;
    step();
    chk_all("abort_t4", 3'b001, 0, 0, 0, 0, 0, 1);
    step();
    chk_all("abort_t5", 3'b001, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
